function_freq_meas: RTL and testbench
=====================================

Name: function_freq_meas

Overview:
- Measurement counterpart to the team's DDS waveform generators. Takes the 8-bit sample stream a generator emits and recovers the frequency control word that produced it.
- Detects midscale rising crossings with hysteresis and counts samples over NPER whole periods.
- A sequential restoring divider then computes the estimate F_est = 256*NPER / samples.
- Used for closed-loop self-check of the F_word path and as a lab frequency meter.

Parameters:
- MID, 128, midscale threshold (unsigned 8-bit).
- HYST, 8, hysteresis half-width. Required: HYST>=1 and MID±HYST within 0..255.
- NPER, 4, periods measured per run. Power of two, 1..16.
- CW, 16, sample-counter and divider width. Required: 256*NPER < 2^CW.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sample_en  input  1  one-cycle strobe; data_in is valid this cycle
- data_in  input  8  unsigned waveform sample
- meas_start  input  1  pulse that starts a measurement; ignored while busy=1
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; results valid in the same cycle
- timeout  output  1  high if the last run aborted; held until the next start
- period_cnt  output  CW  samples counted across NPER periods; held
- f_word_est  output  8  estimated frequency word, saturated to 255; held

Behaviour:
- Reset is asynchronous and active-low; every register clears.
  - busy=0, done=0, timeout=0, period_cnt=0, f_word_est=0.
  - FSM goes to IDLE. Comparator state goes to HI, so a first crossing needs a genuine low first.
- Comparator, updated only when sample_en=1:
  - LO->HI when data_in >= MID+HYST; this transition is a rising event.
  - HI->LO when data_in <= MID-HYST.
  - Otherwise the state holds.
  - Comparator is forced to HI when a start is accepted.
- FSM states: IDLE, ARM, COUNT, DIV, DONE.
- IDLE:
  - On meas_start go to ARM, set busy, clear timeout.
  - Clear the sample counter and the event counter.
- ARM:
  - Each sample_en increments the sample counter (used only for timeout).
  - On the first rising event go to COUNT, sample counter := 0, event counter := 0.
- COUNT:
  - Each sample_en increments the sample counter. The sample that causes a rising event is included.
  - Each rising event increments the event counter.
  - When the event counter reaches NPER: latch the sample counter into period_cnt and go to DIV.
  - Result: period_cnt = NPER * period exactly for integer periods.
- DIV:
  - Restoring division of numerator N = 256*NPER (zero-extended to CW bits) by period_cnt.
  - One quotient bit per cycle, MSB first, exactly CW cycles.
  - Quotient >255 saturates to 255. period_cnt>=2 is guaranteed by the hysteresis, so no divide-by-zero.
- DONE:
  - Single cycle: done=1, f_word_est updated, busy drops the same cycle; then IDLE.
- Latency: done asserts exactly CW+1 rising edges after the edge at which the NPER-th event was recorded.
- Timeout: if the sample counter reaches 2^CW-1 in ARM or COUNT, go directly to DONE.
  - timeout=1, period_cnt=2^CW-1, f_word_est=0.
- Simultaneous meas_start and done: the start is ignored. A new start is accepted only in IDLE.
- Reset mid-run: immediate return to IDLE with all outputs 0; no done pulse.
- Input samples outside ARM/COUNT still update the comparator but are not counted.

Optional Feature:
- Macro FUNCTION_FREQ_MEAS_ROUND_EN.
- Defined: numerator becomes 256*NPER + floor(period_cnt/2), giving a round-to-nearest estimate. Divider width and latency are unchanged; saturation still applies.
- Undefined: truncating quotient, as described above.

Test Plan:
- Ideal 256-entry sine, F_word=4, sample_en every 19 clk -> period_cnt=256, f_word_est=4, timeout=0, done exactly CW+1 edges after the 4th event.
- Same with F_word=16 -> period_cnt=64, f_word_est=16; with F_word=3 -> period_cnt in {341,342}, f_word_est=3.
- Square wave 0/255, 75 samples low / 75 samples high -> period_cnt=600; f_word_est=1 without the macro, 2 with FUNCTION_FREQ_MEAS_ROUND_EN.
- Constant data_in=128 after start -> timeout=1, period_cnt=65535, f_word_est=0; done pulses once.
- Alternating 0/255 every sample (period 2) -> period_cnt=8, quotient 128; with NPER=16 -> 4096/32=128.
- Repeated meas_start while busy -> no restart. rst_n low mid-COUNT -> all outputs 0, no done; a following start measures correctly.

Source files
------------

// File: rtl/function_freq_meas.sv
// function_freq_meas: recovers a DDS frequency word from its sample stream.
// Define FUNCTION_FREQ_MEAS_ROUND_EN for a round-to-nearest estimate.
`default_nettype none

module function_freq_meas #(
   parameter int MID  = 128,
   parameter int HYST = 8,
   parameter int NPER = 4,
   parameter int CW   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sample_en,
   input  logic [7:0]    data_in,
   input  logic          meas_start,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [CW-1:0] period_cnt,
   output logic [7:0]    f_word_est
);

   localparam logic [7:0]    HI_TH = 8'(MID + HYST);
   localparam logic [7:0]    LO_TH = 8'(MID - HYST);
   localparam int            EW    = $clog2(NPER + 1);
   localparam int            BW    = $clog2(CW + 1);
   localparam logic [CW-1:0] NUM   = CW'(256 * NPER);
   localparam logic [CW-1:0] CMAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_COUNT,
      S_DIV,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic          cmp_hi;
   logic          rise;
   logic          accept;
   logic          tmo_hit;
   logic          last_ev;
   logic [CW-1:0] scnt;
   logic [CW-1:0] pc_nx;
   logic [CW-1:0] num_ld;
   logic [EW-1:0] ecnt;
   logic [BW-1:0] bcnt;
   logic [CW-1:0] rem;
   logic [CW-1:0] qn;
   logic [CW:0]   trial;
   logic [CW:0]   diff;

   assign accept  = (state == S_IDLE) && meas_start;
   assign rise    = sample_en && !cmp_hi && (data_in >= HI_TH);
   assign tmo_hit = (scnt == CMAX);
   assign last_ev = rise && (ecnt == EW'(NPER - 1));
   // the sample that completes the last period is counted too
   assign pc_nx   = scnt + CW'(1);

`ifdef FUNCTION_FREQ_MEAS_ROUND_EN
   assign num_ld = NUM + (pc_nx >> 1);
`else
   assign num_ld = NUM;
`endif

   // restoring step: shift one numerator bit into the remainder
   assign trial = {rem, qn[CW-1]};
   assign diff  = trial - {1'b0, period_cnt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_hi <= 1'b1;
      end else if (accept) begin
         cmp_hi <= 1'b1;
      end else if (sample_en) begin
         if (!cmp_hi && data_in >= HI_TH)
            cmp_hi <= 1'b1;
         else if (cmp_hi && data_in <= LO_TH)
            cmp_hi <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:
            if (meas_start) state_nx = S_ARM;
         S_ARM:
            if (tmo_hit)   state_nx = S_DONE;
            else if (rise) state_nx = S_COUNT;
         S_COUNT:
            if (tmo_hit)      state_nx = S_DONE;
            else if (last_ev) state_nx = S_DIV;
         S_DIV:
            if (bcnt == BW'(CW)) state_nx = S_DONE;
         S_DONE:
            state_nx = S_IDLE;
         default:
            state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_ARM) || (state == S_COUNT) || (state == S_DIV);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scnt       <= '0;
         ecnt       <= '0;
         bcnt       <= '0;
         rem        <= '0;
         qn         <= '0;
         timeout    <= 1'b0;
         period_cnt <= '0;
         f_word_est <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               scnt <= '0;
               ecnt <= '0;
               if (meas_start) timeout <= 1'b0;
            end
            S_ARM: begin
               if (tmo_hit) begin
                  timeout    <= 1'b1;
                  period_cnt <= CMAX;
                  f_word_est <= '0;
               end else if (rise) begin
                  scnt <= '0;
                  ecnt <= '0;
               end else if (sample_en) begin
                  scnt <= scnt + CW'(1);
               end
            end
            S_COUNT: begin
               if (tmo_hit) begin
                  timeout    <= 1'b1;
                  period_cnt <= CMAX;
                  f_word_est <= '0;
               end else begin
                  if (sample_en) scnt <= scnt + CW'(1);
                  if (rise)      ecnt <= ecnt + EW'(1);
                  if (last_ev) begin
                     period_cnt <= pc_nx;
                     qn         <= num_ld;
                     rem        <= '0;
                     bcnt       <= '0;
                  end
               end
            end
            S_DIV: begin
               if (bcnt != BW'(CW)) begin
                  rem  <= diff[CW] ? trial[CW-1:0] : diff[CW-1:0];
                  qn   <= {qn[CW-2:0], ~diff[CW]};
                  bcnt <= bcnt + BW'(1);
               end else begin
                  f_word_est <= (|qn[CW-1:8]) ? 8'hff : qn[7:0];
               end
            end
            S_DONE: begin
               scnt <= '0;
            end
            default: begin
               scnt <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_function_freq_meas.sv
// tb_function_freq_meas: scoreboard bench for function_freq_meas.
// Builds waveforms, models the expected count, checks each done pulse.
`timescale 1ns/1ps

module tb_function_freq_meas;

   localparam int CW   = 16;
   localparam int NPER = 4;
   localparam int HI   = 136;
   localparam int LO   = 120;
`ifdef FUNCTION_FREQ_MEAS_ROUND_EN
   localparam int SQ_F = 2;
`else
   localparam int SQ_F = 1;
`endif

   typedef struct {
      int pc;
      int f;
      bit to;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sample_en = 1'b0;
   logic [7:0]    data_in = 8'd0;
   logic          meas_start = 1'b0;
   logic          ms16 = 1'b0;
   logic          busy, done, timeout;
   logic [CW-1:0] period_cnt;
   logic [7:0]    f_word_est;
   logic          busy16, done16, to16;
   logic [CW-1:0] pc16;
   logic [7:0]    f16;

   int npass = 0;
   int ntot = 0;
   int cyc = 0;
   int n_done = 0;
   int n_done16 = 0;
   int d_cyc = 0;
   int d_pc = 0;
   int d_f = 0;
   bit d_to = 1'b0;
   bit d_busy = 1'b0;
   int d_pc16 = 0;
   int d_f16 = 0;
   int ev_cyc = 0;
   int last_cyc = 0;

   logic [7:0] sine [256];
   logic [7:0] wave [$];
   exp_t       sb [$];

   function_freq_meas #(
      .MID(128), .HYST(8), .NPER(NPER), .CW(CW)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
      .data_in(data_in), .meas_start(meas_start),
      .busy(busy), .done(done), .timeout(timeout),
      .period_cnt(period_cnt), .f_word_est(f_word_est)
   );

   function_freq_meas #(
      .MID(128), .HYST(8), .NPER(16), .CW(CW)
   ) u_dut16 (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
      .data_in(data_in), .meas_start(ms16),
      .busy(busy16), .done(done16), .timeout(to16),
      .period_cnt(pc16), .f_word_est(f16)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) begin
         n_done <= n_done + 1;
         d_cyc  <= cyc;
         d_pc   <= int'(period_cnt);
         d_f    <= int'(f_word_est);
         d_to   <= timeout;
         d_busy <= busy;
      end
      if (done16) begin
         n_done16 <= n_done16 + 1;
         d_pc16   <= int'(pc16);
         d_f16    <= int'(f16);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input bit a, input bit b);
      meas_start = a;
      ms16 = b;
      tick();
      meas_start = 1'b0;
      ms16 = 1'b0;
   endtask

   task automatic put(input logic [7:0] d, input int gap);
      sample_en = 1'b1;
      data_in = d;
      tick();
      sample_en = 1'b0;
      last_cyc = cyc;
      repeat (gap - 1) tick();
   endtask

   task automatic stream(input int gap, input int tgt);
      for (int i = 0; i < wave.size(); i++) begin
         put(wave[i], gap);
         if (i == tgt) ev_cyc = last_cyc;
      end
   endtask

   task automatic wait_done(input int n0, input int bound, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < bound && !ok; k++) begin
         if (n_done > n0) ok = 1'b1;
         else tick();
      end
      if (n_done > n0) ok = 1'b1;
   endtask

   task automatic mk_square(input int pre);
      wave.delete();
      repeat (pre) wave.push_back(8'd255);
      repeat (5) begin
         repeat (75) wave.push_back(8'd0);
         repeat (75) wave.push_back(8'd255);
      end
   endtask

   function automatic int expf(input int pc, input int nper);
      int n;
      n = 256 * nper;
`ifdef FUNCTION_FREQ_MEAS_ROUND_EN
      n = n + pc / 2;
`endif
      if (pc == 0) return 0;
      return (n / pc > 255) ? 255 : n / pc;
   endfunction

   // reference: comparator starts high at the accepted start
   function automatic void model(input int nper, output int pc,
                                 output int ev_i);
      bit hi;
      bit armed;
      int cnt;
      int ev;
      hi = 1'b1;
      armed = 1'b1;
      cnt = 0;
      ev = 0;
      pc = 0;
      ev_i = -1;
      for (int i = 0; i < wave.size(); i++) begin
         int d;
         bit r;
         d = int'(wave[i]);
         r = !hi && d >= HI;
         if (r) hi = 1'b1;
         else if (hi && d <= LO) hi = 1'b0;
         if (ev_i < 0) begin
            if (armed) begin
               if (r) armed = 1'b0;
            end else begin
               cnt++;
               if (r) begin
                  ev++;
                  if (ev == nper) begin
                     pc = cnt;
                     ev_i = i;
                  end
               end
            end
         end
      end
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      ntot++;
      if ({busy, done, timeout} !== 3'b000)
         $display("FAIL reset_flags got %b want 000",
                  {busy, done, timeout});
      else npass++;
      ntot++;
      if (period_cnt !== 16'd0)
         $display("FAIL reset_pc got %0d want 0", period_cnt);
      else npass++;
      ntot++;
      if (f_word_est !== 8'd0)
         $display("FAIL reset_f got %0d want 0", f_word_est);
      else npass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_sine();
      int fws[3]  = '{4, 16, 3};
      int gaps[3] = '{19, 19, 4};
      int pcs[3]  = '{256, 64, 341};
      for (int t = 0; t < 3; t++) begin
         int pc, evi, n0, lat;
         bit ok;
         exp_t e;
         wave.delete();
         for (int i = 0; i < 6 * 256 / fws[t] + 8; i++)
            wave.push_back(sine[(192 + fws[t] * i) % 256]);
         model(NPER, pc, evi);
         while (wave.size() > evi + 4) void'(wave.pop_back());
         e.pc = pc;
         e.f = expf(pc, NPER);
         e.to = 1'b0;
         sb.push_back(e);
         n0 = n_done;
         start(1'b1, 1'b0);
         stream(gaps[t], evi);
         wait_done(n0, 200, ok);
         e = sb.pop_front();
         lat = d_cyc - ev_cyc;
         ntot++;
         if (!ok) $display("FAIL sine_done fw=%0d got none want pulse", fws[t]);
         else npass++;
         ntot++;
         if (d_pc !== e.pc)
            $display("FAIL sine_pc fw=%0d got %0d want %0d", fws[t], d_pc, e.pc);
         else npass++;
         ntot++;
         if (fws[t] == 3 ? (d_pc < 341 || d_pc > 342) : (d_pc !== pcs[t]))
            $display("FAIL sine_pc_abs fw=%0d got %0d want %0d", fws[t], d_pc, pcs[t]);
         else npass++;
         ntot++;
         if (d_f !== e.f)
            $display("FAIL sine_f fw=%0d got %0d want %0d", fws[t], d_f, e.f);
         else npass++;
         ntot++;
         if (d_to !== e.to)
            $display("FAIL sine_to fw=%0d got %0d want %0d", fws[t], d_to, e.to);
         else npass++;
         ntot++;
         if (lat !== CW + 1)
            $display("FAIL sine_latency fw=%0d got %0d want %0d", fws[t], lat, CW + 1);
         else npass++;
         ntot++;
         if (d_busy !== 1'b0)
            $display("FAIL sine_busy_at_done got %0d want 0", d_busy);
         else npass++;
         ntot++;
         if (n_done - n0 !== 1)
            $display("FAIL sine_npulse got %0d want 1", n_done - n0);
         else npass++;
      end
   endtask

   task automatic test_square();
      int pc, evi, n0;
      bit ok;
      exp_t e;
      put(8'd0, 1);
      mk_square(40);
      model(NPER, pc, evi);
      while (wave.size() > evi + 4) void'(wave.pop_back());
      e.pc = 600;
      e.f = SQ_F;
      e.to = 1'b0;
      sb.push_back(e);
      n0 = n_done;
      start(1'b1, 1'b0);
      stream(1, evi);
      wait_done(n0, 200, ok);
      e = sb.pop_front();
      ntot++;
      if (!ok) $display("FAIL square_done got none want pulse");
      else npass++;
      ntot++;
      if (d_pc !== e.pc) $display("FAIL square_pc got %0d want %0d", d_pc, e.pc);
      else npass++;
      ntot++;
      if (d_f !== e.f) $display("FAIL square_f got %0d want %0d", d_f, e.f);
      else npass++;
      ntot++;
      if (d_cyc - ev_cyc !== CW + 1)
         $display("FAIL square_latency got %0d want %0d", d_cyc - ev_cyc, CW + 1);
      else npass++;
   endtask

   task automatic test_alternating();
      int pc4, evi4, pc16m, evi16, n0, n16;
      bit ok;
      exp_t e;
      wave.delete();
      for (int i = 0; i < 48; i++) wave.push_back((i % 2) ? 8'd255 : 8'd0);
      model(NPER, pc4, evi4);
      model(16, pc16m, evi16);
      e.pc = 8;
      e.f = 128;
      e.to = 1'b0;
      sb.push_back(e);
      n0 = n_done;
      n16 = n_done16;
      start(1'b1, 1'b1);
      stream(1, evi4);
      wait_done(n0, 100, ok);
      for (int k = 0; k < 100 && n_done16 == n16; k++) tick();
      e = sb.pop_front();
      ntot++;
      if (!ok || d_pc !== e.pc) $display("FAIL alt_pc got %0d want %0d", d_pc, e.pc);
      else npass++;
      ntot++;
      if (d_f !== e.f) $display("FAIL alt_f got %0d want %0d", d_f, e.f);
      else npass++;
      ntot++;
      if (n_done16 == n16) $display("FAIL alt16_done got none want pulse");
      else npass++;
      ntot++;
      if (d_pc16 !== pc16m || d_pc16 !== 32)
         $display("FAIL alt16_pc got %0d want %0d", d_pc16, 32);
      else npass++;
      ntot++;
      if (d_f16 !== expf(32, 16))
         $display("FAIL alt16_f got %0d want %0d", d_f16, expf(32, 16));
      else npass++;
   endtask

   task automatic test_back_to_back();
      int pc, evi, n0;
      exp_t e;
      put(8'd0, 1);
      mk_square(0);
      model(NPER, pc, evi);
      while (wave.size() > evi + 4) void'(wave.pop_back());
      e.pc = 600;
      e.f = SQ_F;
      e.to = 1'b0;
      sb.push_back(e);
      n0 = n_done;
      start(1'b1, 1'b0);
      meas_start = 1'b1;
      stream(1, evi);
      for (int k = 0; k < 100 && cyc < ev_cyc + CW + 1; k++) tick();
      ntot++;
      if (done !== 1'b1) $display("FAIL b2b_done_cycle got %0d want 1", done);
      else npass++;
      tick();
      meas_start = 1'b0;
      ntot++;
      if (busy !== 1'b0) $display("FAIL b2b_start_at_done got busy=%0d want 0", busy);
      else npass++;
      repeat (2) tick();
      e = sb.pop_front();
      ntot++;
      if (n_done - n0 !== 1) $display("FAIL b2b_npulse got %0d want 1", n_done - n0);
      else npass++;
      ntot++;
      if (d_pc !== e.pc) $display("FAIL b2b_pc got %0d want %0d", d_pc, e.pc);
      else npass++;
      ntot++;
      if (busy !== 1'b0) $display("FAIL b2b_idle got busy=%0d want 0", busy);
      else npass++;
   endtask

   task automatic test_timeout();
      int n0;
      exp_t e;
      e.pc = 65535;
      e.f = 0;
      e.to = 1'b1;
      sb.push_back(e);
      n0 = n_done;
      start(1'b1, 1'b0);
      sample_en = 1'b1;
      data_in = 8'd128;
      for (int k = 0; k < 70000 && n_done == n0; k++) tick();
      sample_en = 1'b0;
      repeat (3) tick();
      e = sb.pop_front();
      ntot++;
      if (n_done - n0 !== 1) $display("FAIL tmo_npulse got %0d want 1", n_done - n0);
      else npass++;
      ntot++;
      if (d_pc !== e.pc) $display("FAIL tmo_pc got %0d want %0d", d_pc, e.pc);
      else npass++;
      ntot++;
      if (d_f !== e.f) $display("FAIL tmo_f got %0d want %0d", d_f, e.f);
      else npass++;
      ntot++;
      if (d_to !== e.to) $display("FAIL tmo_flag got %0d want %0d", d_to, e.to);
      else npass++;
   endtask

   task automatic test_reset_mid();
      int pc, evi, n0;
      bit ok;
      exp_t e;
      ntot++;
      if (timeout !== 1'b1) $display("FAIL tmo_held got %0d want 1", timeout);
      else npass++;
      mk_square(0);
      while (wave.size() > 300) void'(wave.pop_back());
      start(1'b1, 1'b0);
      ntot++;
      if ({busy, timeout} !== 2'b10)
         $display("FAIL start_clear got %b want 10", {busy, timeout});
      else npass++;
      n0 = n_done;
      stream(1, -1);
      rst_n = 1'b0;
      #2;
      ntot++;
      if ({busy, done, timeout} !== 3'b000)
         $display("FAIL midrst_flags got %b want 000", {busy, done, timeout});
      else npass++;
      ntot++;
      if (period_cnt !== 16'd0)
         $display("FAIL midrst_pc got %0d want 0", period_cnt);
      else npass++;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (30) tick();
      ntot++;
      if (n_done !== n0) $display("FAIL midrst_nodone got %0d want %0d", n_done, n0);
      else npass++;
      mk_square(0);
      model(NPER, pc, evi);
      while (wave.size() > evi + 4) void'(wave.pop_back());
      e.pc = 600;
      e.f = SQ_F;
      e.to = 1'b0;
      sb.push_back(e);
      start(1'b1, 1'b0);
      stream(1, evi);
      wait_done(n0, 200, ok);
      e = sb.pop_front();
      ntot++;
      if (!ok || d_pc !== e.pc)
         $display("FAIL rerun_pc got %0d want %0d", d_pc, e.pc);
      else npass++;
      ntot++;
      if (d_f !== e.f || d_to !== e.to)
         $display("FAIL rerun_f got %0d/%0d want %0d/%0d", d_f, d_to, e.f, e.to);
      else npass++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         sine[i] = 8'(int'($floor(127.5 + 127.5 *
                   $sin(6.283185307179586 * i / 256.0) + 0.5)));
      test_reset();
      test_sine();
      test_square();
      test_alternating();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
